// File: rtl/perm_engine.sv
// perm_engine: two-stage bank gather/rotate (forward) and un-rotate/scatter (inverse) permutation pipeline
module perm_engine #(
  parameter int DATA_WIDTH = 64,
  parameter int BANK_COUNT = 16,
  parameter int BANK_BITS = $clog2(BANK_COUNT),
  parameter int CNT_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH*BANK_COUNT-1:0] in_data,
  input  logic [BANK_BITS*BANK_COUNT-1:0]  in_bank_sel,
  input  logic [BANK_BITS-1:0]           in_rot,
  input  logic                           in_mode,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH*BANK_COUNT-1:0] out_data,
  output logic                           out_last,
  output logic                           out_err_dup,
  output logic [CNT_WIDTH-1:0]           beat_count
);
  localparam int N = BANK_COUNT;
  localparam int W = DATA_WIDTH;
  localparam int B = BANK_BITS;
  logic [W-1:0] in_w [N];
  logic [B-1:0] sel_w [N];
  logic [W-1:0] s1_d [N];
  logic [W-1:0] s1_q [N];
  logic [B-1:0] s1_sel_q [N];
  logic [W-1:0] s2_d [N];
  logic [N*W-1:0] s2_flat;
  logic [B-1:0] s1_rot_q;
  logic s1_valid_q, s1_mode_q, s1_last_q, s1_dup_q, dup, s1_load, s2_load;
  assign s2_load = !out_valid || out_ready;
  assign s1_load = !s1_valid_q || s2_load;
  assign in_ready = !rst && s1_load;
  for (genvar g = 0; g < N; g++) begin : g_lane
    assign in_w[g] = in_data[g*W +: W];
    assign sel_w[g] = in_bank_sel[g*B +: B];
    assign s2_flat[g*W +: W] = s2_d[g];
  end
  // Lane indices are B bits wide, so the additions below wrap modulo N by truncation.
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < N; i++) begin
      s1_d[i] = in_mode ? in_w[in_rot + B'(i)] : in_w[sel_w[i]];
      for (int j = i + 1; j < N; j++) dup = dup || (sel_w[i] == sel_w[j]);
    end
  end
  // Scatter iterates lanes in ascending order so the highest colliding lane wins; untargeted banks stay zero.
  always_comb begin
    for (int i = 0; i < N; i++) s2_d[i] = '0;
    for (int i = 0; i < N; i++)
      if (s1_mode_q) s2_d[s1_sel_q[i]] = s1_q[i];
      else s2_d[s1_rot_q + B'(i)] = s1_q[i];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      out_err_dup <= 1'b0;
      beat_count <= '0;
    end else begin
      if (out_valid && out_ready) beat_count <= beat_count + CNT_WIDTH'(1);
      if (s2_load) begin
        out_valid <= s1_valid_q;
        if (s1_valid_q) begin
          out_data <= s2_flat;
          out_last <= s1_last_q;
          out_err_dup <= s1_dup_q;
        end
      end
      if (s1_load) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_q <= s1_d;
          s1_sel_q <= sel_w;
          s1_rot_q <= in_rot;
          s1_mode_q <= in_mode;
          s1_last_q <= in_last;
          s1_dup_q <= in_mode && dup;
        end
      end
    end
  end
endmodule

// File: tb/tb_perm_engine.sv
// tb_perm_engine: directed and round-trip self-checking bench for perm_engine
module tb_perm_engine;
  localparam int N = 16;
  localparam int W = 16;
  localparam int B = 4;
  localparam int NW = N*W;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_mode = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [NW-1:0] in_data = '0;
  logic [N*B-1:0] in_bank_sel = '0;
  logic [B-1:0] in_rot = '0;
  logic in_ready, out_valid, out_last, out_err_dup;
  logic [NW-1:0] out_data;
  logic [15:0] beat_count;
  logic c_in_ready, c_out_valid, c_out_last, c_out_err_dup;
  logic [NW-1:0] c_out_data;
  logic [3:0] c_beat_count;
  int n_chk = 0, n_fail = 0, n_acc = 0, n_out = 0;
  logic in_hs = 1'b0, stall_prev = 1'b0;
  logic [NW+1:0] held, b;
  logic [NW+1:0] obs [$];
  logic [NW-1:0] d_id, sel_id, sel_rev, sel5, e;
  logic [NW-1:0] bp_d [20];
  perm_engine #(.DATA_WIDTH(W), .BANK_COUNT(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_bank_sel(in_bank_sel), .in_rot(in_rot), .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_err_dup(out_err_dup), .beat_count(beat_count)
  );
  perm_engine #(.DATA_WIDTH(W), .BANK_COUNT(N), .CNT_WIDTH(4)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data),
    .in_bank_sel(in_bank_sel), .in_rot(in_rot), .in_mode(in_mode), .in_last(in_last),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data), .out_last(c_out_last),
    .out_err_dup(c_out_err_dup), .beat_count(c_beat_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [NW+1:0] got, input logic [NW+1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Samples one time unit before each rising edge: what is seen here is what transfers at that edge.
  always @(negedge clk) begin
    #4;
    if (rst) begin
      in_hs = 1'b0;
      stall_prev = 1'b0;
    end else begin
      in_hs = in_valid && in_ready;
      if (in_hs) n_acc++;
      if (stall_prev) begin
        check("hold_valid", {{NW+1{1'b0}}, out_valid}, 1);
        check("hold_beat", {out_last, out_err_dup, out_data}, held);
      end
      if (out_valid && out_ready) begin
        obs.push_back({out_last, out_err_dup, out_data});
        n_out++;
      end
      stall_prev = out_valid && !out_ready;
      held = {out_last, out_err_dup, out_data};
    end
  end
  task automatic send(input logic [NW-1:0] d, input logic [N*B-1:0] s, input logic [B-1:0] r,
                      input logic m, input logic l);
    int t;
    in_data = d; in_bank_sel = s; in_rot = r; in_mode = m; in_last = l; in_valid = 1'b1;
    t = 0;
    do begin
      @(posedge clk);
      t++;
    end while (!in_hs && t < 200);
    if (!in_hs) check("send_timeout", 0, 1);
    @(negedge clk);
  endtask
  task automatic get(output logic [NW+1:0] o);
    int t;
    t = 0;
    while (obs.size() == 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (obs.size() == 0) begin
      check("out_timeout", 0, 1);
      o = '0;
    end else o = obs.pop_front();
  endtask
  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1 check("rst_in_ready_low", {{NW+1{1'b0}}, in_ready}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", {{NW+1{1'b0}}, out_valid}, 0);
    check("rst_count", {{NW-14{1'b0}}, beat_count}, 0);
    check("rst_in_ready_high", {{NW+1{1'b0}}, in_ready}, 1);
    obs.delete();
    n_acc = 0;
    n_out = 0;
  endtask
  function automatic logic [NW-1:0] fwd_model(input logic [NW-1:0] d, input logic [N*B-1:0] s, input int r);
    logic [NW-1:0] o;
    o = '0;
    for (int i = 0; i < N; i++) o[((r + i) % N)*W +: W] = d[int'(s[i*B +: B])*W +: W];
    return o;
  endfunction
  task automatic round_trip(input int k);
    int p [N];
    int j, t, r;
    logic [NW-1:0] d;
    logic [N*B-1:0] s;
    logic [NW+1:0] o1, o2;
    for (int i = 0; i < N; i++) p[i] = i;
    for (int i = N - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = p[i]; p[i] = p[j]; p[j] = t;
    end
    for (int i = 0; i < N; i++) begin
      s[i*B +: B] = B'(p[i]);
      d[i*W +: W] = W'($urandom);
    end
    r = (k % 4 == 0) ? 15 : int'($urandom_range(0, 15));
    send(d, s, B'(r), 1'b0, 1'b0);
    in_valid = 1'b0;
    get(o1);
    check("rt_fwd", o1, {2'b00, fwd_model(d, s, r)});
    send(o1[NW-1:0], s, B'(r), 1'b1, 1'b0);
    in_valid = 1'b0;
    get(o2);
    check("rt_inv", o2, {2'b00, d});
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < N; i++) begin
      d_id[i*W +: W] = W'(i);
      sel_id[i*B +: B] = B'(i);
      sel_rev[i*B +: B] = B'(15 - i);
      sel5[i*B +: B] = 4'h5;
    end
    do_reset();
    send(d_id, sel_id, 4'd3, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1 check("lat_s1", {{NW+1{1'b0}}, out_valid}, 0);
    @(negedge clk);
    #1 check("lat_s2", {{NW+1{1'b0}}, out_valid}, 1);
    get(b);
    for (int i = 0; i < N; i++) e[((3 + i) % N)*W +: W] = W'(i);
    check("fwd_rot3", b, {2'b00, e});
    check("fwd_lane0", {{NW+2-W{1'b0}}, b[W-1:0]}, 13);
    send(d_id, sel_id, 4'd3, 1'b1, 1'b0);
    send(d_id, sel_rev, 4'd0, 1'b0, 1'b0);
    send(d_id, sel_rev, 4'd2, 1'b1, 1'b0);
    send(d_id, sel5, 4'd0, 1'b1, 1'b0);
    send(d_id, sel5, 4'd0, 1'b0, 1'b0);
    send(d_id, sel_id, 4'd15, 1'b0, 1'b1);
    in_valid = 1'b0;
    get(b);
    for (int i = 0; i < N; i++) e[i*W +: W] = W'((i + 3) % N);
    check("inv_rot3", b, {2'b00, e});
    get(b);
    for (int i = 0; i < N; i++) e[i*W +: W] = W'(15 - i);
    check("fwd_rev", b, {2'b00, e});
    get(b);
    for (int i = 0; i < N; i++) e[(15 - i)*W +: W] = W'((i + 2) % N);
    check("inv_rev2", b, {2'b00, e});
    get(b);
    e = '0;
    e[5*W +: W] = 16'd15;
    check("inv_dup", b, {2'b01, e});
    get(b);
    for (int i = 0; i < N; i++) e[i*W +: W] = 16'd5;
    check("fwd_bcast", b, {2'b00, e});
    get(b);
    for (int i = 0; i < N; i++) e[i*W +: W] = W'((i + 1) % N);
    check("fwd_rot15_last", b, {2'b10, e});
    for (int k = 0; k < 1000; k++) round_trip(k);
    out_ready = 1'b0;
    send(d_id, sel_id, 4'd0, 1'b0, 1'b0);
    send(d_id, sel_id, 4'd1, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1 check("pre_rst_valid", {{NW+1{1'b0}}, out_valid}, 1);
    do_reset();
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("no_stale", n_out, 0);
    for (int k = 0; k < 20; k++)
      for (int i = 0; i < N; i++) bp_d[k][i*W +: W] = W'($urandom);
    obs.delete();
    n_acc = 0;
    n_out = 0;
    fork
      begin
        for (int k = 0; k < 20; k++) send(bp_d[k], sel_id, 4'd0, 1'b0, k == 19);
        in_valid = 1'b0;
      end
      begin
        int t;
        out_ready = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check("bp_fill_two", n_acc, 2);
        check("bp_in_ready_low", {{NW+1{1'b0}}, in_ready}, 0);
        t = 0;
        while (n_out < 20 && t < 600) begin
          if (t == 10) begin
            out_ready = 1'b0;
            repeat (5) @(negedge clk);
          end
          out_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
          t++;
        end
        out_ready = 1'b1;
      end
    join
    repeat (2) @(negedge clk);
    check("bp_n_out", n_out, 20);
    for (int k = 0; k < 20; k++) begin
      get(b);
      check("bp_beat", b, {k == 19, 1'b0, bp_d[k]});
    end
    check("bp_count", {{NW-14{1'b0}}, beat_count}, 20);
    do_reset();
    for (int k = 0; k < 17; k++) send(d_id, sel_id, B'(k), 1'b0, 1'b0);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("cnt_17", {{NW-14{1'b0}}, beat_count}, 17);
    check("cnt_wrap4", {{NW-2{1'b0}}, c_beat_count}, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/perm_engine.md
# perm_engine

Parametrised, pipelined bank-permutation engine for the FFT datapath of the MMH-MH privacy-amplification core. Each beat gathers `BANK_COUNT` words from the memory banks and rotates them into lane order for the FFT. It can also run the exact inverse, un-rotate and scatter, so FFT results are written back to their banks. Sits between the bank array and the FFT butterflies, with valid/ready handshakes on both sides and full one-beat-per-cycle throughput under backpressure.

## Interface
Parameters:
- `DATA_WIDTH`, 64: width of one bank word.
- `BANK_COUNT`, 16: number of banks/lanes; power of two, ≥2.
- `BANK_BITS`, `$clog2(BANK_COUNT)`: lane-index width (derived; not overridden).
- `CNT_WIDTH`, 16: width of the delivered-beat counter.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset, synchronous and active-high.
- `in_valid`, in, 1: input beat valid.
- `in_ready`, out, 1: engine can accept a beat.
- `in_data`, in, `DATA_WIDTH*BANK_COUNT`: bank words; bank b at `[b*DATA_WIDTH +: DATA_WIDTH]`.
- `in_bank_sel`, in, `BANK_BITS*BANK_COUNT`: per-lane bank index `sel[i]` at `[i*BANK_BITS +: BANK_BITS]`.
- `in_rot`, in, `BANK_BITS`: rotation amount `r`.
- `in_mode`, in, 1: 0 = forward (gather, rotate); 1 = inverse (un-rotate, scatter).
- `in_last`, in, 1: marks last beat of an FFT frame.
- `out_valid`, out, 1: output beat valid.
- `out_ready`, in, 1: downstream accepts.
- `out_data`, out, `DATA_WIDTH*BANK_COUNT`: permuted words.
- `out_last`, out, 1: `in_last` carried through with its beat.
- `out_err_dup`, out, 1: beat had duplicate entries in `sel` while in inverse mode.
- `beat_count`, out, `CNT_WIDTH`: beats delivered (`out_valid & out_ready`) since reset.

## Operation
- Forward (mode 0): `out[(r+i) mod N] = in[sel[i]]` for every lane i, with N = `BANK_COUNT`. Duplicate `sel` entries are legal (broadcast) and `out_err_dup` = 0.
- Inverse (mode 1): `out[sel[i]] = in[(r+i) mod N]`. For any permutation `sel`, inverse(forward(x)) = x with the same `sel` and `r`.
- Inverse conflicts: if several i share one `sel[i]`, the highest i wins. Bank lanes never targeted output zero. `out_err_dup` = 1 for that beat.
- Modulo is done by truncation to `BANK_BITS`; `r` and the lane indices wrap naturally.
- Two-register pipeline:
  - S1 latches the gathered vector (forward) or the un-rotated vector (inverse), plus `sel`, `r`, mode, last, and the dup flag.
  - S2 applies the rotation (forward) or the scatter (inverse) and drives the outputs directly from registers.
- Duplicate detection runs combinationally on `in_bank_sel` and is registered into S1, but only when `in_mode`=1.
- `beat_count` increments by 1 on each output handshake and wraps at 2^`CNT_WIDTH` to 0.
- Mode, `sel`, and `r` are per-beat; beats of different modes may be interleaved back-to-back.

## Timing
- Reset (synchronous): S1/S2 valid = 0, `out_valid`=0, `out_data`=0, `out_last`=0, `out_err_dup`=0, `beat_count`=0.
  - `in_ready` = 1 in the first cycle after reset deasserts; it is 0 while `rst` is high.
  - Reset mid-stream discards all in-flight beats; nothing is emitted for them.
- Handshake rules:
  - Transfer occurs when valid & ready are both high at a rising edge.
  - Outputs hold stable while `out_valid`=1 and `out_ready`=0.
  - `in_valid` is not required to wait for `in_ready`.
- Advance rules:
  - `s2_load = !out_valid | out_ready`.
  - `s1_load = !s1_valid | s2_load`.
  - `in_ready = !s1_valid | s2_load`. This is a combinational path from `out_ready`; it is the only one.
- Latency: a beat accepted at edge E is in S1 after E and on the outputs after E+1, so `out_valid` is high in the cycle after acceptance.
- Throughput: with `out_ready` held 1, one beat per cycle, no bubbles.
- Full/stall: with `out_ready`=0, two beats are absorbed (S2, then S1), then `in_ready`=0. One cycle of `out_ready`=1 frees one slot; there is no loss and no duplication.
- Simultaneous out- and in-handshake when full: S2 takes S1, and S1 takes the new beat, in the same edge.

## Test plan
- Reset/idle: assert `rst` for 2 cycles mid-traffic. After the release edge: `out_valid`=0, `beat_count`=0, `in_ready`=1, and no stale beat is ever emitted.
- Forward identity plus rotation: N=16, `sel[i]`=i, `in[b]`=b, r=3. Expect `out[(3+i)%16]`=i (e.g. `out[0]`=13). `out_err_dup`=0, and the beat appears 1 cycle after acceptance.
- Round trip: random permutation `sel`, random r, random data. Forward the beat, feed its output back in inverse mode with the same `sel` and r. Expect the original data bit-exact across 1000 beats, including wrap at r=15.
- Inverse duplicate: `sel`=all 5, r=0, `in[i]`=i. Expect `out[5]`=15, all other lanes 0, `out_err_dup`=1. The same `sel` in forward mode gives `out_err_dup`=0 and all lanes = `in[5]`.
- Backpressure: stream 20 beats with `in_last` on the 20th while `out_ready` toggles randomly (including 5-cycle stalls).
  - In-order, lossless delivery, with outputs stable during stalls.
  - `in_ready` falls only after 2 beats are held.
  - `out_last` is only on the 20th beat, and `beat_count`=20.
- Counter wrap: `CNT_WIDTH`=4, 17 handshakes. Expect `beat_count`=1.
